cpu_bus_watchdog: RTL and testbench

Registered stage between the picorv32 memory interface and the address-decode/mux logic.
- Forwards each CPU access to the decoder and returns the decoder's response one cycle later.
- Bounds every access with a cycle timeout. On expiry it completes the access itself with read data 0x00000000 (the illegal-instruction encoding), so a hung MMIO core causes a trap rather than a CPU stall.
- Keeps error status (sticky flag, saturating count, last faulting address) for firmware or a later TK1 status register.

---
 rtl/cpu_bus_watchdog.sv | 132 +++++++++++++
 tb/tb_cpu_bus_watchdog.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_watchdog
// Description : Registered stage between the picorv32 memory interface and
//               the address decoder. Forwards each access, returns the
//               decoder response one cycle later and bounds every access with
//               a cycle timeout. A timed-out access is completed locally with
//               read data 0 (illegal instruction) and logged in the error
//               status registers.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cpu_valid,
  input  logic [31:0]              cpu_addr,
  input  logic                     cpu_instr,
  input  logic [3:0]               cpu_wstrb,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_rdata,
  output logic                     slave_valid,
  input  logic                     slave_ready,
  input  logic [31:0]              slave_rdata,
  input  logic                     clear_err,
  output logic                     timeout_irq,
  output logic                     timeout_sticky,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [31:0]              last_err_addr,
  output logic                     last_err_instr
);

  localparam int                     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cycle_cnt;
  logic             timeout_hit;
  logic             unused_wstrb;

  // Write strobes travel to the decoder on their own path; writes follow the
  // same handshake as reads, so the watchdog itself never looks at them.
  assign unused_wstrb = ^cpu_wstrb;

  // Only the WAIT state exposes the request; the IDLE bubble after each
  // response guarantees the decoder sees slave_valid low between accesses.
  assign slave_valid = (state == S_WAIT) && cpu_valid;

  // A ready response on the last allowed cycle beats the timeout.
  assign timeout_hit = (state == S_WAIT) && !slave_ready && (cycle_cnt == CNT_LAST);

  // Access FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cycle_cnt   <= '0;
      cpu_ready   <= 1'b0;
      cpu_rdata   <= 32'h0000_0000;
      timeout_irq <= 1'b0;
    end else begin
      cpu_ready   <= 1'b0;
      timeout_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_valid) begin
            state     <= S_WAIT;
            cycle_cnt <= '0;
          end
        end
        S_WAIT: begin
          cycle_cnt <= cycle_cnt + CNT_ONE;
          if (slave_ready) begin
            state     <= S_RESP;
            cpu_ready <= 1'b1;
            cpu_rdata <= slave_rdata;
          end else if (timeout_hit) begin
            state       <= S_RESP;
            cpu_ready   <= 1'b1;
            cpu_rdata   <= 32'h0000_0000;
            timeout_irq <= 1'b1;
          end else if (!cpu_valid) begin
            // CPU withdrew the request: drop it silently.
            state <= S_IDLE;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Error status; a timeout in the same cycle as clear_err takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timeout_sticky <= 1'b0;
      err_count      <= '0;
      last_err_addr  <= 32'h0000_0000;
      last_err_instr <= 1'b0;
    end else if (timeout_hit) begin
      timeout_sticky <= 1'b1;
      last_err_addr  <= cpu_addr;
      last_err_instr <= cpu_instr;
      if (clear_err) begin
        err_count <= ERR_ONE;
      end else if (err_count != ERR_MAX) begin
        err_count <= err_count + ERR_ONE;
      end
    end else if (clear_err) begin
      timeout_sticky <= 1'b0;
      err_count      <= '0;
      last_err_addr  <= 32'h0000_0000;
      last_err_instr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_watchdog
// Description : Directed self-checking bench for cpu_bus_watchdog
//               (TIMEOUT_CYCLES=8, ERR_CNT_WIDTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_watchdog;

  logic        clk;
  logic        reset_n;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic        cpu_instr;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        slave_valid;
  logic        slave_ready;
  logic [31:0] slave_rdata;
  logic        clear_err;
  logic        timeout_irq;
  logic        timeout_sticky;
  logic [1:0]  err_count;
  logic [31:0] last_err_addr;
  logic        last_err_instr;

  int checks   = 0;
  int failures = 0;

  cpu_bus_watchdog #(
    .TIMEOUT_CYCLES(8),
    .ERR_CNT_WIDTH (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_valid     (cpu_valid),
    .cpu_addr      (cpu_addr),
    .cpu_instr     (cpu_instr),
    .cpu_wstrb     (cpu_wstrb),
    .cpu_ready     (cpu_ready),
    .cpu_rdata     (cpu_rdata),
    .slave_valid   (slave_valid),
    .slave_ready   (slave_ready),
    .slave_rdata   (slave_rdata),
    .clear_err     (clear_err),
    .timeout_irq   (timeout_irq),
    .timeout_sticky(timeout_sticky),
    .err_count     (err_count),
    .last_err_addr (last_err_addr),
    .last_err_instr(last_err_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL time_limit: simulation still running at 200000");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; values are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one access. Cycle k is the cycle following the k-th edge after
  // cpu_valid is raised (edge 1 moves IDLE->WAIT). slave_ready is driven in
  // cycle ready_at (0 = never), clear_err in cycle clear_at (0 = never).
  // Returns on the cpu_ready cycle, or after a 40-cycle budget.
  task automatic access(input logic [31:0] addr, input logic instr,
                        input int ready_at, input logic [31:0] rd,
                        input int clear_at,
                        output int resp_cycle, output int sv_count,
                        output int irq_count, output logic [31:0] rdata_seen);
    cpu_valid   = 1'b1;
    cpu_addr    = addr;
    cpu_instr   = instr;
    slave_rdata = rd;
    resp_cycle  = 0;
    sv_count    = 0;
    irq_count   = 0;
    rdata_seen  = 32'hx;
    for (int k = 1; k <= 40 && resp_cycle == 0; k++) begin
      tick();
      if (slave_valid) sv_count++;
      if (timeout_irq) irq_count++;
      clear_err = (k == clear_at);
      if (cpu_ready) begin
        resp_cycle  = k;
        rdata_seen  = cpu_rdata;
        cpu_valid   = 1'b0;
        slave_ready = 1'b0;
        clear_err   = 1'b0;
      end else begin
        slave_ready = (k == ready_at);
      end
    end
  endtask

  // Cycle after a response: pulse outputs must be gone.
  task automatic post(input string tag);
    tick();
    check({tag, "_ready_drop"}, 32'(cpu_ready), 32'd0);
    check({tag, "_irq_drop"}, 32'(timeout_irq), 32'd0);
  endtask

  int          rc, sv, irq, pulses;
  logic [31:0] rdv;
  logic [31:0] addr_tab [5];

  initial begin
    reset_n     = 1'b0;
    cpu_valid   = 1'b0;
    cpu_addr    = 32'h0;
    cpu_instr   = 1'b0;
    cpu_wstrb   = 4'h0;
    slave_ready = 1'b0;
    slave_rdata = 32'h0;
    clear_err   = 1'b0;
    addr_tab    = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008,
                    32'h1000_000C, 32'h1000_0010};

    tick();
    tick();
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_sv", 32'(slave_valid), 32'd0);
    check("rst_irq", 32'(timeout_irq), 32'd0);
    check("rst_sticky", 32'(timeout_sticky), 32'd0);
    check("rst_cnt", 32'(err_count), 32'd0);
    check("rst_addr", last_err_addr, 32'h0);
    reset_n = 1'b1;
    tick();

    // Normal read: ready in the third WAIT cycle.
    access(32'h4000_0010, 1'b0, 3, 32'hDEAD_BEEF, 0, rc, sv, irq, rdv);
    check("rd_resp_cycle", 32'(rc), 32'd4);
    check("rd_sv_cycles", 32'(sv), 32'd3);
    check("rd_rdata", rdv, 32'hDEAD_BEEF);
    check("rd_irq", 32'(irq), 32'd0);
    post("rd");
    check("rd_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_cnt", 32'(err_count), 32'd0);
    check("rd_sticky", 32'(timeout_sticky), 32'd0);

    // Write with quick ready (same flow).
    cpu_wstrb = 4'hF;
    access(32'h4000_0020, 1'b0, 1, 32'h0000_1111, 0, rc, sv, irq, rdv);
    check("wr_resp_cycle", 32'(rc), 32'd2);
    check("wr_sv_cycles", 32'(sv), 32'd1);
    cpu_wstrb = 4'h0;
    post("wr");

    // Timeout on an instruction fetch.
    access(32'hC100_0004, 1'b1, 0, 32'hFFFF_FFFF, 0, rc, sv, irq, rdv);
    check("to_resp_cycle", 32'(rc), 32'd9);
    check("to_sv_cycles", 32'(sv), 32'd8);
    check("to_rdata", rdv, 32'h0);
    check("to_irq", 32'(irq), 32'd1);
    check("to_sticky", 32'(timeout_sticky), 32'd1);
    check("to_cnt", 32'(err_count), 32'd1);
    check("to_addr", last_err_addr, 32'hC100_0004);
    check("to_instr", 32'(last_err_instr), 32'd1);
    post("to");
    check("to_sticky_hold", 32'(timeout_sticky), 32'd1);

    // Race: ready on the final timeout cycle wins.
    access(32'h5000_0000, 1'b0, 8, 32'h1234_5678, 0, rc, sv, irq, rdv);
    check("race_resp_cycle", 32'(rc), 32'd9);
    check("race_rdata", rdv, 32'h1234_5678);
    check("race_irq", 32'(irq), 32'd0);
    check("race_cnt", 32'(err_count), 32'd1);
    check("race_addr", last_err_addr, 32'hC100_0004);
    post("race");

    // Clear before the saturation run.
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr1_cnt", 32'(err_count), 32'd0);
    check("clr1_sticky", 32'(timeout_sticky), 32'd0);
    check("clr1_addr", last_err_addr, 32'h0);
    check("clr1_instr", 32'(last_err_instr), 32'd0);

    // Saturation: counts 1,2,3,3,3.
    for (int i = 0; i < 5; i++) begin
      access(addr_tab[i], 1'(i % 2), 0, 32'hFFFF_FFFF, 0, rc, sv, irq, rdv);
      check($sformatf("sat%0d_cnt", i), 32'(err_count), (i < 3) ? 32'(i + 1) : 32'd3);
      check($sformatf("sat%0d_irq", i), 32'(irq), 32'd1);
      post($sformatf("sat%0d", i));
    end
    check("sat_addr", last_err_addr, 32'h1000_0010);
    check("sat_instr", 32'(last_err_instr), 32'd0);
    check("sat_sticky", 32'(timeout_sticky), 32'd1);

    // Clear in the same cycle as a timeout: timeout wins.
    access(32'hC200_0008, 1'b1, 0, 32'hFFFF_FFFF, 8, rc, sv, irq, rdv);
    check("coll_resp_cycle", 32'(rc), 32'd9);
    check("coll_cnt", 32'(err_count), 32'd1);
    check("coll_sticky", 32'(timeout_sticky), 32'd1);
    check("coll_addr", last_err_addr, 32'hC200_0008);
    post("coll");

    // Protocol violation: request withdrawn in WAIT, no response, no log.
    cpu_valid = 1'b1;
    cpu_addr  = 32'h6000_0000;
    tick();
    tick();
    check("pv_sv", 32'(slave_valid), 32'd1);
    cpu_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cpu_ready || timeout_irq) pulses++;
    end
    check("pv_pulses", 32'(pulses), 32'd0);
    check("pv_cnt", 32'(err_count), 32'd1);

    // Reset in the middle of WAIT abandons the access and clears status.
    cpu_valid = 1'b1;
    cpu_addr  = 32'h7000_0000;
    tick();
    tick();
    check("rw_sv", 32'(slave_valid), 32'd1);
    reset_n   = 1'b0;
    cpu_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rw_ready", 32'(cpu_ready), 32'd0);
    check("rw_sticky", 32'(timeout_sticky), 32'd0);
    check("rw_cnt", 32'(err_count), 32'd0);
    check("rw_addr", last_err_addr, 32'h0);
    check("rw_instr", 32'(last_err_instr), 32'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (cpu_ready || timeout_irq) pulses++;
    end
    check("rw_pulses", 32'(pulses), 32'd0);
    access(32'h4000_0030, 1'b0, 2, 32'hAAAA_5555, 0, rc, sv, irq, rdv);
    check("rw_next_cycle", 32'(rc), 32'd3);
    check("rw_next_rdata", rdv, 32'hAAAA_5555);
    post("rw_next");

    // Timeout then a lone clear.
    access(32'hC300_000C, 1'b1, 0, 32'hFFFF_FFFF, 0, rc, sv, irq, rdv);
    check("pre_clr_cnt", 32'(err_count), 32'd1);
    post("pre_clr");
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr2_cnt", 32'(err_count), 32'd0);
    check("clr2_sticky", 32'(timeout_sticky), 32'd0);
    check("clr2_addr", last_err_addr, 32'h0);
    check("clr2_instr", 32'(last_err_instr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
